// File: rtl/vga_timing_pkg.sv
// XGA raster constants, count type and total-width checks
// shared by the timing source and the drawing stages.
package vga_timing_pkg;

   localparam int CNT_W   = 11;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam int H_ACTIVE = 1024;
   localparam int H_FP     = 24;
   localparam int H_SYNC   = 136;
   localparam int H_BP     = 160;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 768;
   localparam int V_FP     = 3;
   localparam int V_SYNC   = 6;
   localparam int V_BP     = 29;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam logic SYNC_ACT = 1'b1;

   typedef logic [CNT_W-1:0] cnt_t;

   // A total must be representable by the count type.
   function automatic bit total_fits(int total);
      return (total >= 1) && (total <= CNT_MAX);
   endfunction

   localparam bit XGA_FITS = total_fits(H_TOTAL)
                          && total_fits(V_TOTAL);

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: counters, syncs, blanks, frame pulse.
// master drives it (timing source), slave reads it (draw stages).
interface vga_timing_if;
   import vga_timing_pkg::*;

   cnt_t hcount;
   logic hsync;
   logic hblnk;
   cnt_t vcount;
   logic vsync;
   logic vblnk;
   logic frame_start;

   modport master (
      output hcount, hsync, hblnk,
      output vcount, vsync, vblnk,
      output frame_start
   );

   modport slave (
      input hcount, hsync, hblnk,
      input vcount, vsync, vblnk,
      input frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with advance enable.
// Ports: clk_i, rst_i (async high), en_i advance; cnt_o count,
// blnk_o (count >= ACTIVE), sync_o, wrap_o (count at last value).
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   ACTIVE  = H_ACTIVE,
   parameter int   FP      = H_FP,
   parameter int   SYNC    = H_SYNC,
   parameter int   BP      = H_BP,
   parameter logic ACT_LVL = SYNC_ACT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output cnt_t cnt_o,
   output logic blnk_o,
   output logic sync_o,
   output logic wrap_o
);

   localparam int   TOTAL = ACTIVE + FP + SYNC + BP;
   localparam cnt_t LAST  = cnt_t'(TOTAL - 1);
   localparam cnt_t ACT_C = cnt_t'(ACTIVE);
   localparam cnt_t SS_C  = cnt_t'(ACTIVE + FP);
   localparam cnt_t SE_C  = cnt_t'(ACTIVE + FP + SYNC - 1);

   if (!total_fits(TOTAL)) begin : g_bad_total
      $error("vga_axis_counter: total exceeds count width");
   end

   cnt_t cnt_q, cnt_d;
   logic blnk_q, blnk_d;
   logic sync_q, sync_d;
   logic last;

   assign last = (cnt_q == LAST);

   // Flags come from the next count so they stay
   // aligned with the count they are registered with.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = last ? '0 : cnt_q + cnt_t'(1);
      end
      blnk_d = (cnt_d >= ACT_C);
      sync_d = ((cnt_d >= SS_C) && (cnt_d <= SE_C))
             ? ACT_LVL : ~ACT_LVL;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         blnk_q <= 1'b0;
         sync_q <= ~ACT_LVL;
      end else begin
         cnt_q  <= cnt_d;
         blnk_q <= blnk_d;
         sync_q <= sync_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign blnk_o = blnk_q;
   assign sync_o = sync_q;
   assign wrap_o = last;

endmodule

// File: rtl/vga_timing.sv
// Raster timing source: horizontal/vertical counters, syncs,
// blanks and frame pulse. Ports: pclk, rst (async high), vga (master).
module vga_timing #(
   parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int   H_FP     = vga_timing_pkg::H_FP,
   parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int   H_BP     = vga_timing_pkg::H_BP,
   parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int   V_FP     = vga_timing_pkg::V_FP,
   parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int   V_BP     = vga_timing_pkg::V_BP,
   parameter logic SYNC_ACT = vga_timing_pkg::SYNC_ACT
) (
   input  logic         pclk,
   input  logic         rst,
   vga_timing_if.master vga
);
   import vga_timing_pkg::*;

   if (!XGA_FITS) begin : g_bad_xga
      $error("vga_timing: XGA totals exceed count width");
   end

   cnt_t h_cnt, v_cnt;
   logic h_blnk, h_sync, h_wrap;
   logic v_blnk, v_sync, v_wrap;
   logic fs_q, fs_d;

   vga_axis_counter #(
      .ACTIVE  (H_ACTIVE),
      .FP      (H_FP),
      .SYNC    (H_SYNC),
      .BP      (H_BP),
      .ACT_LVL (SYNC_ACT)
   ) u_h (
      .clk_i  (pclk),
      .rst_i  (rst),
      .en_i   (1'b1),
      .cnt_o  (h_cnt),
      .blnk_o (h_blnk),
      .sync_o (h_sync),
      .wrap_o (h_wrap)
   );

   // Vertical advances on the horizontal carry, so vsync
   // and vblnk change only where hcount returns to 0.
   vga_axis_counter #(
      .ACTIVE  (V_ACTIVE),
      .FP      (V_FP),
      .SYNC    (V_SYNC),
      .BP      (V_BP),
      .ACT_LVL (SYNC_ACT)
   ) u_v (
      .clk_i  (pclk),
      .rst_i  (rst),
      .en_i   (h_wrap),
      .cnt_o  (v_cnt),
      .blnk_o (v_blnk),
      .sync_o (v_sync),
      .wrap_o (v_wrap)
   );

   // Next position is (0,0) exactly when both axes wrap.
   assign fs_d = h_wrap & v_wrap;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         fs_q <= 1'b1;
      end else begin
         fs_q <= fs_d;
      end
   end

   assign vga.hcount      = h_cnt;
   assign vga.hsync       = h_sync;
   assign vga.hblnk       = h_blnk;
   assign vga.vcount      = v_cnt;
   assign vga.vsync       = v_sync;
   assign vga.vblnk       = v_blnk;
   assign vga.frame_start = fs_q;

endmodule
